// File: rtl/maze_pkg.sv
// Shared encodings for the BFS maze solver: move directions, FSM states and
// the row/column step helpers used by both the search and the backtrack.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_POP,
    S_EXPL,
    S_BACK,
    S_OUT,
    S_FAIL,
    S_CLEAR
  } state_t;

  function automatic int dir_drow(input dir_t d);
    case (d)
      DIR_DOWN: return 1;
      DIR_UP:   return -1;
      default:  return 0;
    endcase
  endfunction

  function automatic int dir_dcol(input dir_t d);
    case (d)
      DIR_RIGHT: return 1;
      DIR_LEFT:  return -1;
      default:   return 0;
    endcase
  endfunction

  // RIGHT<->LEFT and DOWN<->UP differ only in the top bit.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/maze_fifo.sv
// Show-ahead synchronous FIFO holding the BFS frontier; the head entry is
// visible on deq_data whenever empty is low.
module maze_fifo
  import maze_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_enq;
  logic                  do_deq;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_enq   = enq_valid && !full;
  assign do_deq   = deq_ready && !empty;
  assign deq_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: rtl/maze_bfs_solver.sv
// Serial-load BFS maze solver: loads a MAZE_W x MAZE_W bitmap, searches from
// (0,0) to the far corner and streams the shortest path as 2-bit moves.
module maze_bfs_solver
  import maze_pkg::*;
#(
  parameter int MAZE_W      = 17,
  parameter int QUEUE_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in,
  output logic       out_valid,
  output logic [1:0] out,
  output logic       out_last,
  output logic       out_fail
);

  localparam int CW    = $clog2(MAZE_W);
  localparam int NCELL = MAZE_W * MAZE_W;
  localparam int IW    = $clog2(NCELL);
  localparam logic [IW-1:0] GOAL_IDX = IW'(NCELL - 1);

  state_t state, state_n;

  logic [NCELL-1:0] maze_open;
  logic [NCELL-1:0] visited;
  logic [1:0]       parent [NCELL];
  logic [1:0]       path_stack [NCELL-1];

  logic [IW-1:0] load_idx;
  logic [IW-1:0] pos;
  logic [IW-1:0] sp;
  logic [IW-1:0] nb_idx;
  logic [IW-1:0] back_next;
  logic [CW-1:0] cur_row, cur_col;
  logic [CW-1:0] nb_row, nb_col;
  logic [1:0]    dir;
  logic [1:0]    back_dir;
  int            nr, nc, back_step;
  logic          nb_ok, nb_goal;

  logic            enq_valid, deq_ready, fifo_clr;
  logic            fifo_full, fifo_empty;
  logic [2*CW-1:0] enq_data, deq_data;

  maze_fifo #(
    .DATA_WIDTH(2 * CW),
    .DEPTH     (QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fifo_clr),
    .enq_valid(enq_valid),
    .enq_data (enq_data),
    .deq_ready(deq_ready),
    .deq_data (deq_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Signed arithmetic so stepping off row/col 0 shows up as -1, not a wrap.
  always_comb begin
    nr     = int'(cur_row) + dir_drow(dir_t'(dir));
    nc     = int'(cur_col) + dir_dcol(dir_t'(dir));
    nb_row = CW'(nr);
    nb_col = CW'(nc);
    nb_idx = '0;
    nb_ok  = 1'b0;
    if (nr >= 0 && nr < MAZE_W && nc >= 0 && nc < MAZE_W) begin
      nb_idx = IW'(nr * MAZE_W + nc);
      nb_ok  = maze_open[nb_idx] && !visited[nb_idx];
    end
    nb_goal = (nb_idx == GOAL_IDX);
  end

  always_comb begin
    back_dir  = parent[pos];
    back_step = dir_drow(dir_opposite(dir_t'(back_dir))) * MAZE_W
              + dir_dcol(dir_opposite(dir_t'(back_dir)));
    back_next = IW'(int'(pos) + back_step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    out_valid = 1'b0;
    out       = 2'd0;
    out_last  = 1'b0;
    out_fail  = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    fifo_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) state_n = S_LOAD;
      end
      S_LOAD: begin
        if (in_valid && load_idx == GOAL_IDX) begin
          if (!maze_open[0] || !in) begin
            state_n = S_FAIL;
          end else begin
            enq_valid = 1'b1;
            state_n   = S_POP;
          end
        end
      end
      S_POP: begin
        if (fifo_empty) begin
          state_n = S_FAIL;
        end else begin
          deq_ready = 1'b1;
          state_n   = S_EXPL;
        end
      end
      S_EXPL: begin
        if (nb_ok && fifo_full) begin
          state_n = S_FAIL;
        end else if (nb_ok) begin
          enq_valid = 1'b1;
          enq_data  = {nb_row, nb_col};
          if (nb_goal)            state_n = S_BACK;
          else if (dir == 2'd3)   state_n = S_POP;
        end else if (dir == 2'd3) begin
          state_n = S_POP;
        end
      end
      S_BACK: begin
        if (back_next == '0) state_n = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out       = path_stack[sp - 1'b1];
        out_last  = (sp == IW'(1));
        if (sp == IW'(1)) state_n = S_CLEAR;
      end
      S_FAIL: begin
        out_valid = 1'b1;
        out_fail  = 1'b1;
        out_last  = 1'b1;
        state_n   = S_CLEAR;
      end
      S_CLEAR: begin
        fifo_clr = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The stack fills goal-first, so popping it replays the path start-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maze_open <= '0;
      visited   <= '0;
      load_idx  <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      dir       <= '0;
      pos       <= '0;
      sp        <= '0;
      for (int i = 0; i < NCELL; i++)     parent[i]     <= '0;
      for (int i = 0; i < NCELL - 1; i++) path_stack[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            maze_open[0] <= in;
            load_idx     <= IW'(1);
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            maze_open[load_idx] <= in;
            load_idx            <= load_idx + 1'b1;
            if (load_idx == GOAL_IDX) visited[0] <= 1'b1;
          end
        end
        S_POP: begin
          if (!fifo_empty) begin
            {cur_row, cur_col} <= deq_data;
            dir                <= 2'd0;
          end
        end
        S_EXPL: begin
          dir <= dir + 2'd1;
          pos <= GOAL_IDX;
          if (nb_ok && !fifo_full) begin
            visited[nb_idx] <= 1'b1;
            parent[nb_idx]  <= dir;
          end
        end
        S_BACK: begin
          path_stack[sp] <= back_dir;
          sp             <= sp + 1'b1;
          pos            <= back_next;
        end
        S_OUT: begin
          sp <= sp - 1'b1;
        end
        S_CLEAR: begin
          visited  <= '0;
          load_idx <= '0;
          sp       <= '0;
          for (int i = 0; i < NCELL; i++) parent[i] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_bfs_solver.sv
// Scoreboard bench for maze_bfs_solver: a plain BFS model builds the expected
// beat stream per frame and a negedge monitor compares every DUT beat.
module tb_maze_bfs_solver;

  localparam int W      = 5;
  localparam int DEPTH  = 4;
  localparam int NC     = W * W;
  localparam int BUDGET = 12 * NC + 40;

  typedef struct {
    logic [1:0] mv;
    logic       last;
    logic       fail;
  } beat_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit   = 1'b0;
  logic       out_valid;
  logic [1:0] out_mv;
  logic       out_last;
  logic       out_fail;

  bit    grid [NC];
  beat_t exp_q [$];
  int    model_path [$];
  bit    model_fail;
  int    total   = 0;
  int    bad     = 0;
  bit    in_path = 1'b0;

  maze_bfs_solver #(
    .MAZE_W     (W),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in       (in_bit),
    .out_valid(out_valid),
    .out      (out_mv),
    .out_last (out_last),
    .out_fail (out_fail)
  );

  always #5 clk = ~clk;

  // Textbook BFS over the grid with a bounded frontier; moves 0..3 are
  // right, down, left, up, tried in that order for each dequeued cell.
  function automatic void modelSolve();
    int  q [$];
    bit  seen [NC];
    int  par [NC];
    int  cur, r, c, nr, nc, ni, p;
    bit  found, failed;
    found  = 0;
    failed = 0;
    model_path.delete();
    if (!grid[0] || !grid[NC-1]) failed = 1;
    else begin
      q.push_back(0);
      seen[0] = 1;
      while (!found && !failed) begin
        if (q.size() == 0) failed = 1;
        else begin
          cur = q.pop_front();
          r = cur / W;
          c = cur % W;
          for (int d = 0; d < 4 && !found && !failed; d++) begin
            nr = r; nc = c;
            case (d)
              0: nc = c + 1;
              1: nr = r + 1;
              2: nc = c - 1;
              default: nr = r - 1;
            endcase
            if (nr >= 0 && nr < W && nc >= 0 && nc < W) begin
              ni = nr * W + nc;
              if (grid[ni] && !seen[ni]) begin
                if (q.size() == DEPTH) failed = 1;
                else begin
                  q.push_back(ni);
                  seen[ni] = 1;
                  par[ni]  = d;
                  if (ni == NC - 1) found = 1;
                end
              end
            end
          end
        end
      end
    end
    if (found) begin
      p = NC - 1;
      while (p != 0) begin
        model_path.push_front(par[p]);
        case (par[p])
          0: p = p - 1;
          1: p = p - W;
          2: p = p + 1;
          default: p = p + W;
        endcase
      end
    end
    model_fail = failed;
  endfunction

  function automatic void pushExpected();
    beat_t b;
    modelSolve();
    if (model_fail) begin
      b.mv = 2'd0; b.last = 1'b1; b.fail = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < model_path.size(); i++) begin
        b.mv   = 2'(model_path[i]);
        b.last = (i == model_path.size() - 1);
        b.fail = 1'b0;
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic sendBits();
    for (int i = 0; i < NC; i++) begin
      in_valid = 1'b1;
      in_bit   = grid[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic applyStimulus(input string tag);
    int cycles;
    cycles = 0;
    pushExpected();
    sendBits();
    while (exp_q.size() != 0 && cycles < BUDGET) begin
      @(posedge clk); #1;
      cycles++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s completion: %0d beats still pending after %0d cycles, required 0",
               tag, exp_q.size(), cycles);
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic checkOutput();
    beat_t e;
    if (in_path) begin
      total++;
      if (!out_valid) begin
        bad++;
        $display("[TB] FAIL path_gap: got out_valid=0, required 1 (path beats must be contiguous)");
      end
    end
    if (out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_beat: got out=%0d last=%0b fail=%0b, required no beat",
                 out_mv, out_last, out_fail);
      end else begin
        e = exp_q.pop_front();
        if (out_mv !== e.mv || out_last !== e.last || out_fail !== e.fail) begin
          bad++;
          $display("[TB] FAIL beat: got out=%0d last=%0b fail=%0b, required out=%0d last=%0b fail=%0b",
                   out_mv, out_last, out_fail, e.mv, e.last, e.fail);
        end
      end
      in_path = !out_last;
    end else begin
      in_path = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) checkOutput();
  end

  task automatic checkResetOutputs(input string tag);
    total++;
    if (out_valid !== 1'b0 || out_mv !== 2'd0 || out_last !== 1'b0 || out_fail !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%0b out=%0d last=%0b fail=%0b, required all 0",
               tag, out_valid, out_mv, out_last, out_fail);
    end
  endtask

  task automatic fillGrid(input bit val);
    for (int i = 0; i < NC; i++) grid[i] = val;
  endtask

  // Abort an all-open frame one cycle into its first exploration step; no
  // expectation is queued, so any beat after the abort is reported.
  task automatic resetMidFrame();
    fillGrid(1'b1);
    sendBits();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    in_path = 1'b0;
    checkResetOutputs("reset_in_expl");
    @(posedge clk); #1;
    checkResetOutputs("reset_held");
    rst_n = 1'b1;
    repeat (3 * NC) begin @(posedge clk); #1; end
  endtask

  task automatic buildSnake();
    fillGrid(1'b0);
    for (int c = 0; c < W; c++) begin
      grid[0 * W + c] = 1'b1;
      grid[2 * W + c] = 1'b1;
      grid[4 * W + c] = 1'b1;
    end
    grid[1 * W + (W - 1)] = 1'b1;
    grid[3 * W + 0]       = 1'b1;
  endtask

  initial begin
    int dens;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    fillGrid(1'b1);
    applyStimulus("all_open_overflow");

    fillGrid(1'b1); grid[0] = 1'b0;
    applyStimulus("start_wall");
    applyStimulus("start_wall_again");

    fillGrid(1'b1); grid[NC-1] = 1'b0;
    applyStimulus("goal_wall");

    fillGrid(1'b1);
    for (int c = 0; c < W; c++) grid[2 * W + c] = 1'b0;
    applyStimulus("row2_walls");

    buildSnake();
    applyStimulus("snake");

    fillGrid(1'b1);
    for (int r = 0; r < W - 1; r++) grid[r * W + 1] = 1'b0;
    applyStimulus("column_corridor");

    resetMidFrame();
    buildSnake();
    applyStimulus("after_reset");

    for (int f = 0; f < 40; f++) begin
      dens = $urandom_range(50, 85);
      for (int i = 0; i < NC; i++) grid[i] = ($urandom_range(0, 99) < dens);
      if ($urandom_range(0, 9) != 0) begin
        grid[0]    = 1'b1;
        grid[NC-1] = 1'b1;
      end
      applyStimulus("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
